dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of 64-bit doubleword entries (power of two, 2..256).
REQ-002 SHALL have parameter LATENCY, default 2, cycles spent in BUSY (1..15).
REQ-003 SHALL have port Clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  1  the MEM stage presents a request.
REQ-006 SHALL have port req_ready  output  1  the responder accepts a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  64  byte address.
REQ-009 SHALL have port req_wdata  input  64  store data.
REQ-010 SHALL have port resp_valid  output  1  the response is present.
REQ-011 SHALL have port resp_ready  input  1  the MEM stage consumes the response.
REQ-012 SHALL have port resp_rdata  output  64  load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  the request was misaligned or out of range.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-015 SHALL assert req_ready only in IDLE.
REQ-016 Acceptance SHALL occur when req_valid and req_ready are both high at a clock edge; on acceptance the block SHALL latch write, addr and wdata, load the counter with LATENCY-1, and go to BUSY.
REQ-017 In BUSY, the counter SHALL decrement each cycle; at count 0 the block SHALL perform the access and go to RESP on the next edge.
REQ-018 Request-to-response latency SHALL be exactly LATENCY+1 cycles from the acceptance edge to the first cycle with resp_valid high.
REQ-019 Index SHALL be addr[3+log2(DEPTH)-1:3].
REQ-020 An error SHALL be raised when addr[2:0] is nonzero or addr >= DEPTH*8.
REQ-021 On an error the block SHALL perform no write, drive resp_rdata = 0, and drive resp_err = 1.
REQ-022 A store SHALL write the full 64 bits at the transition to RESP.
REQ-023 A load SHALL register the entry's contents into resp_rdata at the same transition.
REQ-024 In RESP, resp_valid, resp_rdata and resp_err SHALL stay stable until resp_ready is high; then the block SHALL return to IDLE.
REQ-025 There SHALL be no back-to-back acceptance: the minimum request interval is LATENCY+2 cycles.
REQ-026 req_valid deasserted while in BUSY or RESP SHALL have no effect.
REQ-027 Changes on the request inputs after acceptance SHALL be ignored.
REQ-028 resp_ready high outside RESP SHALL be ignored.
REQ-029 A load after a store to the same index SHALL return the stored value (no stale read).

Reset
REQ-030 On Rst_n low, the FSM SHALL go to IDLE, the counter to 0, and resp_valid, resp_rdata and resp_err to 0.
REQ-031 req_ready SHALL be 1 one cycle after Rst_n deassertion.
REQ-032 Storage contents SHALL be cleared to 0 by reset.
REQ-033 Reset during BUSY SHALL abort the access with no write and no response.
REQ-034 Reset during RESP SHALL drop the pending response.

Structure
REQ-035 The shared package SHALL hold the FSM state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2) and the DW_BYTES=8 constant.
REQ-036 The storage array SHALL be one sub-module, dmem_array: a synchronous-write, registered-read DEPTH x 64 array with clear-on-reset.
REQ-037 The FSM and counter SHALL live in dmem_responder.

Verification
REQ-038 Scenario: reset, then store addr 0x10, data 0xDEADBEEF_00000001, resp_ready=1 -> resp_valid appears 3 cycles after acceptance with resp_err=0 and resp_rdata=0.
REQ-039 Scenario: load addr 0x10 after that store -> resp_rdata=0xDEADBEEF_00000001, resp_err=0.
REQ-040 Scenario: load addr 0x13 (misaligned) and addr 0x100 (out of range) -> resp_err=1 and resp_rdata=0; a following load of 0xF8 returns its prior value unchanged.
REQ-041 Scenario: hold resp_ready=0 for 5 cycles in RESP -> outputs stable; req_ready=0 throughout; IDLE is reached one cycle after resp_ready rises.
REQ-042 Scenario: assert Rst_n low mid-BUSY on a store to 0x20 -> no response; a subsequent load of 0x20 returns 0.
REQ-043 Scenario: keep req_valid high continuously with changing addresses -> acceptances exactly every LATENCY+2 cycles (4 with defaults), each using the address present at acceptance.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and
// doubleword geometry.
package dmem_responder_pkg;

    localparam int DW_BYTES = 8;
    localparam int DW_SHIFT = $clog2(DW_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64-bit storage with synchronous write, registered read and
// asynchronous clear of every entry on reset.
module dmem_array #(
    parameter  int DEPTH = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] idx,
    input  logic [63:0]      wdata,
    output logic [63:0]      rdata
);

    logic [63:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (wr_en) begin
                mem[idx] <= wdata;
            end
            if (rd_en) begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one request, waits
// LATENCY cycles in BUSY, then holds the response until it is consumed.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output state_t      dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid may not depend on ready, and a response, once
    // valid, holds its payload unchanged until the edge that transfers it.

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic        lat_write_q;
    logic [63:0] lat_addr_q;
    logic [63:0] lat_wdata_q;
    logic        resp_err_q;
    logic        accept;
    logic        access;
    logic        addr_err;
    logic        mem_wr;
    logic        mem_rd;
    logic [63:0] arr_rdata;

    // Anything above the last doubleword index is out of range.
    assign addr_err = (lat_addr_q[DW_SHIFT-1:0] != '0) ||
                      (lat_addr_q[63:DW_SHIFT+IDX_W] != '0);

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        access    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = req_valid && req_ready;
    assign mem_wr = access && lat_write_q && !addr_err;
    assign mem_rd = access && !lat_write_q && !addr_err;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lat_write_q <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                lat_write_q <= req_write;
                lat_addr_q  <= req_addr;
                lat_wdata_q <= req_wdata;
                cnt_q       <= CNT_INIT;
            end else if (state_q == BUSY && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (access) begin
                resp_err_q <= addr_err;
            end
        end
    end

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (Clk),
        .rst_n (Rst_n),
        .wr_en (mem_wr),
        .rd_en (mem_rd),
        .idx   (lat_addr_q[DW_SHIFT +: IDX_W]),
        .wdata (lat_wdata_q),
        .rdata (arr_rdata)
    );

    // The array read register keeps stale data, so only successful loads expose it.
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid && resp_err_q;
    assign resp_rdata = (resp_valid && !lat_write_q && !resp_err_q) ? arr_rdata : '0;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: fixed vector table, hand-written reset and
// streaming sequences, and random traffic against a flat memory model.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int DEPTH   = 32;
    localparam int LATENCY = 2;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    state_t      dbg_state;

    always #5 Clk = ~Clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dbg_state  (dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a flat array of doublewords plus expected-response queues.
    logic [63:0] model_mem [DEPTH];
    logic [63:0] exp_q[$];
    logic        exp_err_q[$];

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          hold;
        logic        exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[10];

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    task automatic model_access(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                                output logic err, output logic [63:0] rdata);
        int idx;
        err   = (addr % 64'd8 != 64'd0) || (addr >= 64'(DEPTH * 8));
        rdata = '0;
        idx   = int'(addr / 64'd8 % 64'(DEPTH));
        if (!err) begin
            if (wr) model_mem[idx] = wdata;
            else    rdata = model_mem[idx];
        end
    endtask

    // Called #1 after a rising edge with the DUT idle (or about to be).
    task automatic run_txn(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                           input int hold, output logic got_err, output logic [63:0] got_rdata);
        int          guard;
        int          edges;
        logic        m_err;
        logic [63:0] m_rdata;
        logic        e_err;
        logic [63:0] e_rdata;
        got_err   = 1'b0;
        got_rdata = '0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        resp_ready = 1'b0;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge Clk); #1;
            guard++;
        end
        if (!req_ready) begin
            check1("req_ready_timeout", req_ready, 1'b1);
            req_valid = 1'b0;
            return;
        end
        @(posedge Clk); #1;
        model_access(wr, addr, wdata, m_err, m_rdata);
        exp_q.push_back(m_rdata);
        exp_err_q.push_back(m_err);
        // Request inputs are garbage after acceptance and must be ignored.
        req_valid = 1'($urandom_range(0, 1));
        req_write = ~wr;
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        edges = 0;
        while (!resp_valid && edges < 40) begin
            resp_ready = 1'($urandom_range(0, 1));
            @(posedge Clk); #1;
            edges++;
        end
        // Counted inclusive of the acceptance cycle.
        check_int("latency_cycles", edges + 1, LATENCY + 1);
        e_rdata = exp_q.pop_front();
        e_err   = exp_err_q.pop_front();
        if (!resp_valid) begin
            req_valid = 1'b0;
            resp_ready = 1'b0;
            return;
        end
        got_err   = resp_err;
        got_rdata = resp_rdata;
        check1("resp_err_model", resp_err, e_err);
        check64("resp_rdata_model", resp_rdata, e_rdata);
        check1("req_ready_in_resp", req_ready, 1'b0);
        for (int i = 0; i < hold; i++) begin
            resp_ready = 1'b0;
            req_valid  = 1'($urandom_range(0, 1));
            @(posedge Clk); #1;
            check1("hold_resp_valid", resp_valid, 1'b1);
            check1("hold_resp_err", resp_err, got_err);
            check64("hold_resp_rdata", resp_rdata, got_rdata);
            check1("hold_req_ready", req_ready, 1'b0);
        end
        resp_ready = 1'b1;
        req_valid  = 1'b0;
        @(posedge Clk); #1;
        resp_ready = 1'b0;
        check1("idle_after_consume", req_ready, 1'b1);
        check1("resp_valid_after_consume", resp_valid, 1'b0);
    endtask

    // req_valid held high with a fresh load address every cycle.
    task automatic stream_test(input int cycles);
        int          last_acc;
        int          n_acc;
        logic        m_err;
        logic [63:0] m_rdata;
        logic [63:0] a;
        last_acc   = -1;
        n_acc      = 0;
        resp_ready = 1'b1;
        req_write  = 1'b0;
        req_valid  = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            a = 64'($urandom_range(0, DEPTH - 1)) * 64'd8;
            req_addr  = a;
            req_wdata = {$urandom, $urandom};
            if (resp_valid) begin
                if (exp_q.size() == 0) check1("stream_unexpected_resp", resp_valid, 1'b0);
                else begin
                    check64("stream_rdata", resp_rdata, exp_q.pop_front());
                    check1("stream_err", resp_err, exp_err_q.pop_front());
                end
            end
            if (req_ready) begin
                if (last_acc >= 0) check_int("accept_interval", c - last_acc, LATENCY + 2);
                last_acc = c;
                n_acc++;
                model_access(1'b0, a, '0, m_err, m_rdata);
                exp_q.push_back(m_rdata);
                exp_err_q.push_back(m_err);
            end
            @(posedge Clk); #1;
        end
        req_valid = 1'b0;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
            if (resp_valid) begin
                check64("stream_rdata", resp_rdata, exp_q.pop_front());
                check1("stream_err", resp_err, exp_err_q.pop_front());
            end
            @(posedge Clk); #1;
        end
        check_int("stream_drained", exp_q.size(), 0);
        check1("stream_enough_accepts", n_acc >= 5, 1'b1);
        resp_ready = 1'b0;
        @(posedge Clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        g_err;
        logic [63:0] g_rdata;
        logic        saw_resp;
        logic        wr;
        logic [63:0] addr;
        int          kind;

        vecs[0] = '{1'b1, 64'h10,  64'hDEADBEEF_00000001, 0, 1'b0, 64'h0};
        vecs[1] = '{1'b0, 64'h10,  64'h0,                 0, 1'b0, 64'hDEADBEEF_00000001};
        vecs[2] = '{1'b1, 64'hF8,  64'h0123_4567_89AB_CDEF, 1, 1'b0, 64'h0};
        vecs[3] = '{1'b0, 64'h13,  64'h0,                 0, 1'b1, 64'h0};
        vecs[4] = '{1'b0, 64'h100, 64'h0,                 2, 1'b1, 64'h0};
        vecs[5] = '{1'b1, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1, 64'h0};
        vecs[6] = '{1'b0, 64'hF8,  64'h0,                 5, 1'b0, 64'h0123_4567_89AB_CDEF};
        vecs[7] = '{1'b1, 64'h0C,  64'hAAAA_5555_AAAA_5555, 0, 1'b1, 64'h0};
        vecs[8] = '{1'b0, 64'h08,  64'h0,                 0, 1'b0, 64'h0};
        vecs[9] = '{1'b0, 64'h10,  64'h0,                 3, 1'b0, 64'hDEADBEEF_00000001};

        // Clock/reset.
        model_clear();
        Rst_n      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        #2 Rst_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check1("reset_resp_valid", resp_valid, 1'b0);
        check1("reset_resp_err", resp_err, 1'b0);
        check64("reset_resp_rdata", resp_rdata, 64'h0);
        check_int("reset_state", int'(dbg_state), int'(IDLE));
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        check1("req_ready_after_reset", req_ready, 1'b1);

        // Fixed vectors.
        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].hold, g_err, g_rdata);
            check1($sformatf("vec%0d_err", i), g_err, vecs[i].exp_err);
            check64($sformatf("vec%0d_rdata", i), g_rdata, vecs[i].exp_rdata);
        end

        // Reset in the middle of a store.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h20;
        req_wdata = 64'hCAFE_F00D_1234_5678;
        @(posedge Clk); #1;
        check_int("midbusy_state", int'(dbg_state), int'(BUSY));
        req_valid = 1'b0;
        Rst_n = 1'b0;
        #1;
        check1("midbusy_reset_no_resp", resp_valid, 1'b0);
        check_int("midbusy_reset_state", int'(dbg_state), int'(IDLE));
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        model_clear();
        saw_resp = 1'b0;
        resp_ready = 1'b1;
        repeat (6) begin
            @(posedge Clk); #1;
            if (resp_valid) saw_resp = 1'b1;
        end
        resp_ready = 1'b0;
        check1("midbusy_no_late_resp", saw_resp, 1'b0);
        run_txn(1'b0, 64'h20, '0, 0, g_err, g_rdata);
        check64("load_0x20_after_reset", g_rdata, 64'h0);
        run_txn(1'b0, 64'h10, '0, 0, g_err, g_rdata);
        check64("load_0x10_cleared", g_rdata, 64'h0);

        // Random traffic.
        for (int n = 0; n < 60; n++) begin
            wr   = 1'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 4));
            case (kind)
                0, 1, 2: addr = 64'($urandom_range(0, DEPTH - 1)) * 64'd8;
                3:       addr = 64'($urandom_range(0, DEPTH - 1)) * 64'd8 + 64'($urandom_range(1, 7));
                default: addr = ($urandom_range(0, 1) == 0) ? 64'(DEPTH * 8) + 64'($urandom_range(0, 255))
                                                            : {$urandom, $urandom} | 64'h8000_0000_0000_0000;
            endcase
            run_txn(wr, addr, {$urandom, $urandom}, int'($urandom_range(0, 3)), g_err, g_rdata);
        end

        stream_test(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
